dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bridge directly downstream of the RV32I core's dmem port. Accepts word load/store requests from the core through a valid/ready handshake and buffers them in a small in-order request FIFO. Issues them to a variable-latency word-addressed memory port and returns each load's data to the core as a single-cycle response pulse. Stores are posted and produce no core response; only one load is outstanding at the memory at a time.

## Interface
- DEPTH, 2: request FIFO entries (power of two, ≥2)
- ADDR_W, 30: memory word-address width (byte address bits [ADDR_W+1:2])
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- dmem_req_valid  in  1  core request valid
- dmem_req_we  in  1  1 = store, 0 = load
- dmem_req_addr  in  32  byte address
- dmem_req_data  in  32  store data
- dmem_req_ready  out  1  bridge can accept a request this cycle
- dmem_resp_valid  out  1  load data valid (one-cycle pulse per load)
- dmem_resp_data  out  32  load data
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  store flag
- mem_req_addr  out  ADDR_W  word address
- mem_req_wdata  out  32  store data
- mem_resp_valid  in  1  memory read data valid
- mem_resp_rdata  in  32  memory read data
- err_misaligned  out  1  sticky: a request with addr[1:0]≠0 was seen
- err_protocol  out  1  sticky: mem_resp_valid arrived with no load outstanding
- bridge_idle  out  1  FIFO empty and no load outstanding

## Operation
- Reset values: dmem_req_ready=1, dmem_resp_valid=0, dmem_resp_data=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, err_*=0, bridge_idle=1. FIFO pointers and count are 0; state is IDLE.
- Accept: push on dmem_req_valid && dmem_req_ready. dmem_req_ready = !full.
  - A full FIFO refuses a push even if it pops in the same cycle.
- Misaligned request (addr[1:0]≠0): accepted normally and set err_misaligned.
  - Store: dropped at issue, never sent to memory.
  - Load: completes locally with dmem_resp_data=0 instead of going to memory.
- Issue FSM:
  - IDLE: if the FIFO is non-empty and the head is aligned, drive mem_req_valid=1 with the head fields, all taken from registers.
    - On mem_req_ready, pop. A store stays in IDLE; a load goes to WAIT.
    - A misaligned head pops without asserting mem_req_valid. A misaligned load goes to LOCAL.
  - WAIT: mem_req_valid=0. On mem_resp_valid, capture rdata and go to RESP.
  - RESP: dmem_resp_valid=1 for exactly one cycle with the captured data, then go to IDLE.
  - LOCAL: dmem_resp_valid=1 with data 0 for one cycle, then go to IDLE.
- Requests complete in order. A store behind a load is not issued until that load's response cycle has passed.
- mem_resp_valid in any state other than WAIT: ignored, and err_protocol is set.
- Error flags clear only on reset.
- mem_req_addr = dmem_req_addr[ADDR_W+1:2].

## Timing
- Request accepted at cycle T: earliest mem_req_valid is T+1, because the FIFO is registered with no bypass.
- A load issued at cycle I with mem_resp_valid at cycle R (R ≥ I+1): dmem_resp_valid at R+1.
  - Minimum core-visible load latency is 3 cycles (T → T+3).
- Back-to-back stores with mem_req_ready=1: one issued per cycle. Sustained throughput is 1 store/cycle with DEPTH ≥ 2.
- mem_req_* is held stable while mem_req_valid=1 && !mem_req_ready.
- Reset mid-operation: FIFO and FSM are cleared in the same cycle and any captured load is discarded. The memory is reset on the same reset.

## Test plan
- Single store: addr 0x100, data 0xDEADBEEF, mem_req_ready=1 → mem_req_valid at T+1 with addr 0x40, we=1, wdata 0xDEADBEEF; no dmem_resp_valid.
- Single load, memory returns 0x12345678 one cycle after issue → dmem_resp_valid=1 with 0x12345678 at T+3 for exactly one cycle.
- Backpressure:
  - Hold mem_req_ready=0 and present 3 stores → dmem_req_ready drops to 0 after 2 accepts.
  - Release mem_req_ready → stores reach memory in order.
- Load then store, memory delays the response 5 cycles → the store's mem_req_valid does not appear until after dmem_resp_valid.
- Misaligned load at 0x102 → err_misaligned=1, no mem_req_valid, dmem_resp_valid with data 0.
- Stray and reset cases:
  - Stray mem_resp_valid while idle → err_protocol=1.
  - Reset asserted during WAIT → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: core dmem port, memory port and status signals of dmem_bridge.
interface dmem_bridge_if #(parameter int ADDR_W = 30);
  logic              dmem_req_valid;
  logic              dmem_req_we;
  logic [31:0]       dmem_req_addr;
  logic [31:0]       dmem_req_data;
  logic              dmem_req_ready;
  logic              dmem_resp_valid;
  logic [31:0]       dmem_resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_rdata;
  logic              err_misaligned;
  logic              err_protocol;
  logic              bridge_idle;
  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_data,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_data,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           err_misaligned, err_protocol, bridge_idle
  );
  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_data,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_data,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           err_misaligned, err_protocol, bridge_idle
  );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: in-order load/store bridge from the core dmem port to a variable-latency word memory.
module dmem_bridge #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 30
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dmem_bridge_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, LOCAL} state_e;
  state_e            state_q, state_d;
  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       cnt_q;
  logic [DEPTH-1:0]  we_q, mis_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       rdata_q, rdata_d;
  logic              err_mis_q, err_prot_q;
  logic              full, empty, push, pop, head_we, head_mis;
  assign full     = cnt_q == (PW+1)'(DEPTH);
  assign empty    = cnt_q == '0;
  assign push     = bus.dmem_req_valid && !full;
  assign head_we  = we_q[rd_q];
  assign head_mis = mis_q[rd_q];
  // misaligned heads retire without touching memory; loads among them answer locally
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    bus.mem_req_valid = state_q == IDLE && !empty && !head_mis;
    pop = state_q == IDLE && !empty && (head_mis || bus.mem_req_ready);
    case (state_q)
      IDLE:    if (pop && !head_we) state_d = head_mis ? LOCAL : WAIT;
      WAIT:    if (bus.mem_resp_valid) begin
        state_d = RESP;
        rdata_d = bus.mem_resp_rdata;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_mis_q  <= 1'b0;
      err_prot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      wr_q       <= push ? wr_q + 1'b1 : wr_q;
      rd_q       <= pop ? rd_q + 1'b1 : rd_q;
      cnt_q      <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      err_mis_q  <= err_mis_q || (push && bus.dmem_req_addr[1:0] != 2'b00);
      err_prot_q <= err_prot_q || (bus.mem_resp_valid && state_q != WAIT);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      we_q[wr_q]   <= bus.dmem_req_we;
      mis_q[wr_q]  <= bus.dmem_req_addr[1:0] != 2'b00;
      addr_q[wr_q] <= bus.dmem_req_addr[ADDR_W+1:2];
      data_q[wr_q] <= bus.dmem_req_data;
    end
  end
  // request fields are gated so they read zero whenever nothing is offered
  assign bus.mem_req_we      = bus.mem_req_valid && head_we;
  assign bus.mem_req_addr    = bus.mem_req_valid ? addr_q[rd_q] : '0;
  assign bus.mem_req_wdata   = bus.mem_req_valid ? data_q[rd_q] : '0;
  assign bus.dmem_req_ready  = !full;
  assign bus.dmem_resp_valid = state_q == RESP || state_q == LOCAL;
  assign bus.dmem_resp_data  = state_q == RESP ? rdata_q : '0;
  assign bus.err_misaligned  = err_mis_q;
  assign bus.err_protocol    = err_prot_q;
  assign bus.bridge_idle     = empty && state_q == IDLE;
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed and randomized checks of dmem_bridge against a request-level memory model.
module tb_dmem_bridge;
  localparam int ADDR_W = 30;
  localparam logic [100:0] RST_OUTS = {1'b1, 99'd0, 1'b1};
  typedef struct {logic we; logic [ADDR_W-1:0] addr; logic [31:0] wdata; int c;} mreq_t;
  typedef struct {logic [31:0] data; int c;} resp_t;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0, cyc = 0;
  mreq_t issued[$];
  resp_t resps[$];
  logic [31:0] mem_model [int];
  int mem_lat = 1, pend_at = 0, stab_err = 0;
  bit pend = 0, last_stall = 0;
  logic [31:0] pend_data;
  mreq_t last;
  always #5 clk = ~clk;
  dmem_bridge_if #(.ADDR_W(ADDR_W)) bus ();
  dmem_bridge #(.DEPTH(2), .ADDR_W(ADDR_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  function automatic logic [31:0] dflt(input logic [ADDR_W-1:0] a);
    return {a[27:0], 4'h5} ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [100:0] outs();
    return {bus.dmem_req_ready, bus.dmem_resp_valid, bus.dmem_resp_data, bus.mem_req_valid,
            bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.err_misaligned,
            bus.err_protocol, bus.bridge_idle};
  endfunction
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dmem_req_valid = 1;
    bus.dmem_req_we = we;
    bus.dmem_req_addr = a;
    bus.dmem_req_data = d;
  endtask
  initial forever @(posedge clk) cyc++;
  // memory: answers each load after mem_lat cycles (0 = random 1..4)
  initial forever begin
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 0;
    if (pend && cyc == pend_at) begin
      bus.mem_resp_valid = 1;
      bus.mem_resp_rdata = pend_data;
      pend = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      issued.push_back('{bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, cyc});
      if (bus.mem_req_we) mem_model[int'(bus.mem_req_addr)] = bus.mem_req_wdata;
      else begin
        pend = 1;
        pend_at = cyc + (mem_lat > 0 ? mem_lat : int'($urandom_range(1, 4)));
        pend_data = mem_model.exists(int'(bus.mem_req_addr)) ? mem_model[int'(bus.mem_req_addr)] : dflt(bus.mem_req_addr);
      end
    end
    if (last_stall && (!bus.mem_req_valid || bus.mem_req_we !== last.we || bus.mem_req_addr !== last.addr || bus.mem_req_wdata !== last.wdata)) stab_err++;
    last_stall = bus.mem_req_valid && !bus.mem_req_ready;
    last = '{bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, cyc};
    if (bus.dmem_resp_valid) resps.push_back('{bus.dmem_resp_data, cyc});
  end
  task automatic test_reset;
    rst = 1;
    repeat (2) tick;
    @(negedge clk);
    checks++;
    if (outs() !== RST_OUTS) begin errors++; $display("FAIL reset_outs got %h want %h", outs(), RST_OUTS); end
    tick;
    rst = 0;
  endtask
  task automatic test_single_store;
    issued.delete(); resps.delete();
    tick;
    bus.mem_req_ready = 1;
    drive(1, 32'h100, 32'hDEADBEEF);
    tick;
    bus.dmem_req_valid = 0;
    @(negedge clk);
    checks++;
    if (!(bus.mem_req_valid === 1 && bus.mem_req_we === 1 && bus.mem_req_addr === 30'h40 && bus.mem_req_wdata === 32'hDEADBEEF)) begin
      errors++; $display("FAIL store_issue got v%b we%b a%h d%h want v1 we1 a40 dDEADBEEF", bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata);
    end
    tick;
    @(negedge clk);
    checks++;
    if (bus.mem_req_valid !== 0) begin errors++; $display("FAIL store_once got %b want 0", bus.mem_req_valid); end
    repeat (3) tick;
    checks++;
    if (resps.size() != 0 || issued.size() != 1) begin errors++; $display("FAIL store_noresp got resps %0d issued %0d want 0 1", resps.size(), issued.size()); end
  endtask
  task automatic test_single_load;
    issued.delete(); resps.delete();
    mem_lat = 1;
    mem_model[32'h50] = 32'h12345678;
    tick;
    drive(0, 32'h140, 32'h0);
    tick;
    bus.dmem_req_valid = 0;
    repeat (2) tick;
    @(negedge clk);
    checks++;
    if (bus.dmem_resp_valid !== 1 || bus.dmem_resp_data !== 32'h12345678) begin
      errors++; $display("FAIL load_t3 got v%b d%h want v1 d12345678", bus.dmem_resp_valid, bus.dmem_resp_data);
    end
    tick;
    @(negedge clk);
    checks++;
    if (bus.dmem_resp_valid !== 0) begin errors++; $display("FAIL load_pulse got %b want 0", bus.dmem_resp_valid); end
  endtask
  task automatic test_backpressure;
    bit acc = 0;
    issued.delete(); resps.delete();
    bus.mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      drive(1, 32'h200 + 4 * i, 32'hA0 + i);
      @(negedge clk);
      checks++;
      if (bus.dmem_req_ready !== (i < 2)) begin errors++; $display("FAIL bp_ready%0d got %b want %b", i, bus.dmem_req_ready, i < 2); end
    end
    tick;
    bus.mem_req_ready = 1;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      acc = bus.dmem_req_ready;
      if (!acc) tick;
    end
    tick;
    bus.dmem_req_valid = 0;
    checks++;
    if (!acc) begin errors++; $display("FAIL bp_accept got 0 want 1"); end
    repeat (5) tick;
    checks++;
    if (issued.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", issued.size()); end
    for (int i = 0; i < 3 && i < issued.size(); i++) begin
      checks++;
      if (issued[i].addr !== 30'(32'h80 + i) || issued[i].wdata !== 32'hA0 + i) begin
        errors++; $display("FAIL bp_order%0d got a%h d%h want a%h d%h", i, issued[i].addr, issued[i].wdata, 32'h80 + i, 32'hA0 + i);
      end
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL bp_stable got %0d want 0", stab_err); end
  endtask
  task automatic test_load_then_store;
    issued.delete(); resps.delete();
    mem_lat = 5;
    tick;
    drive(0, 32'h300, 32'h0);
    tick;
    drive(1, 32'h304, 32'hCAFEF00D);
    tick;
    bus.dmem_req_valid = 0;
    for (int k = 0; k < 40 && issued.size() < 2; k++) tick;
    checks++;
    if (issued.size() != 2 || resps.size() != 1) begin
      errors++; $display("FAIL ls_counts got issued %0d resps %0d want 2 1", issued.size(), resps.size());
    end else begin
      checks++;
      if (resps[0].data !== dflt(30'hC0)) begin errors++; $display("FAIL ls_data got %h want %h", resps[0].data, dflt(30'hC0)); end
      checks++;
      if (resps[0].c != issued[0].c + 6) begin errors++; $display("FAIL ls_latency got %0d want %0d", resps[0].c, issued[0].c + 6); end
      checks++;
      if (issued[1].c <= resps[0].c || issued[1].we !== 1) begin
        errors++; $display("FAIL ls_order got store cycle %0d want after %0d", issued[1].c, resps[0].c);
      end
    end
    mem_lat = 1;
  endtask
  task automatic test_random;
    mreq_t exp_mem[$];
    logic [31:0] exp_resp[$];
    logic [31:0] ref_mem [int];
    logic have = 0, rwe = 0;
    logic [31:0] ra = 0, rd = 0;
    int sent = 0, guard = 0;
    issued.delete(); resps.delete(); mem_model.delete();
    mem_lat = 0;
    while (sent < 150 && guard < 3000) begin
      tick;
      guard++;
      bus.mem_req_ready = $urandom_range(0, 3) != 0;
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1;
        rwe = 1'($urandom_range(0, 1));
        ra = 32'h400 + 4 * $urandom_range(0, 7) + ($urandom_range(0, 9) == 0 ? $urandom_range(1, 3) : 0);
        rd = $urandom;
      end
      bus.dmem_req_valid = have;
      bus.dmem_req_we = rwe;
      bus.dmem_req_addr = ra;
      bus.dmem_req_data = rd;
      @(negedge clk);
      if (have && bus.dmem_req_ready) begin
        have = 0;
        sent++;
        if (ra[1:0] != 0) begin
          if (!rwe) exp_resp.push_back(32'h0);
        end else if (rwe) begin
          exp_mem.push_back('{1'b1, ra[31:2], rd, 0});
          ref_mem[int'(ra[31:2])] = rd;
        end else begin
          exp_mem.push_back('{1'b0, ra[31:2], 32'h0, 0});
          exp_resp.push_back(ref_mem.exists(int'(ra[31:2])) ? ref_mem[int'(ra[31:2])] : dflt(ra[31:2]));
        end
      end
    end
    tick;
    bus.dmem_req_valid = 0;
    bus.mem_req_ready = 1;
    for (int k = 0; k < 300 && !(bus.bridge_idle && issued.size() >= exp_mem.size() && resps.size() >= exp_resp.size()); k++) tick;
    checks++;
    if (sent != 150 || issued.size() != exp_mem.size() || resps.size() != exp_resp.size()) begin
      errors++; $display("FAIL rnd_counts got sent %0d mem %0d resp %0d want 150 %0d %0d", sent, issued.size(), resps.size(), exp_mem.size(), exp_resp.size());
    end
    for (int i = 0; i < exp_mem.size() && i < issued.size(); i++) begin
      checks++;
      if (issued[i].we !== exp_mem[i].we || issued[i].addr !== exp_mem[i].addr || (exp_mem[i].we && issued[i].wdata !== exp_mem[i].wdata)) begin
        errors++; $display("FAIL rnd_mem%0d got we%b a%h d%h want we%b a%h d%h", i, issued[i].we, issued[i].addr, issued[i].wdata, exp_mem[i].we, exp_mem[i].addr, exp_mem[i].wdata);
      end
    end
    for (int i = 0; i < exp_resp.size() && i < resps.size(); i++) begin
      checks++;
      if (resps[i].data !== exp_resp[i]) begin errors++; $display("FAIL rnd_resp%0d got %h want %h", i, resps[i].data, exp_resp[i]); end
    end
    checks++;
    if (stab_err != 0 || bus.err_protocol !== 0) begin errors++; $display("FAIL rnd_stable got stab %0d prot %b want 0 0", stab_err, bus.err_protocol); end
    mem_lat = 1;
  endtask
  task automatic test_misaligned;
    rst = 1;
    pend = 0;
    tick;
    rst = 0;
    issued.delete(); resps.delete();
    @(negedge clk);
    checks++;
    if (bus.err_misaligned !== 0) begin errors++; $display("FAIL mis_pre got %b want 0", bus.err_misaligned); end
    tick;
    drive(0, 32'h102, 32'h0);
    tick;
    bus.dmem_req_valid = 0;
    repeat (4) tick;
    checks++;
    if (bus.err_misaligned !== 1 || issued.size() != 0 || resps.size() != 1) begin
      errors++; $display("FAIL mis_load got err %b issued %0d resps %0d want 1 0 1", bus.err_misaligned, issued.size(), resps.size());
    end else begin
      checks++;
      if (resps[0].data !== 0) begin errors++; $display("FAIL mis_data got %h want 0", resps[0].data); end
    end
  endtask
  task automatic test_stray;
    resps.delete();
    @(negedge clk);
    checks++;
    if (bus.err_protocol !== 0) begin errors++; $display("FAIL stray_pre got %b want 0", bus.err_protocol); end
    tick;
    bus.mem_resp_valid = 1;
    bus.mem_resp_rdata = 32'h77;
    tick;
    bus.mem_resp_valid = 0;
    @(negedge clk);
    checks++;
    if (bus.err_protocol !== 1 || resps.size() != 0) begin errors++; $display("FAIL stray got err %b resps %0d want 1 0", bus.err_protocol, resps.size()); end
  endtask
  task automatic test_reset_wait;
    resps.delete();
    mem_lat = 20;
    tick;
    drive(0, 32'h500, 32'h0);
    tick;
    bus.dmem_req_valid = 0;
    repeat (3) tick;
    @(negedge clk);
    checks++;
    if (bus.bridge_idle !== 0) begin errors++; $display("FAIL rw_busy got %b want 0", bus.bridge_idle); end
    tick;
    rst = 1;
    pend = 0;
    tick;
    @(negedge clk);
    checks++;
    if (outs() !== RST_OUTS) begin errors++; $display("FAIL rw_outs got %h want %h", outs(), RST_OUTS); end
    rst = 0;
    repeat (25) tick;
    checks++;
    if (resps.size() != 0) begin errors++; $display("FAIL rw_discard got %0d want 0", resps.size()); end
    mem_lat = 1;
  endtask
  initial begin
    bus.dmem_req_valid = 0;
    bus.dmem_req_we = 0;
    bus.dmem_req_addr = 0;
    bus.dmem_req_data = 0;
    bus.mem_req_ready = 0;
    bus.mem_resp_valid = 0;
    bus.mem_resp_rdata = 0;
    test_reset();
    test_single_store();
    test_single_load();
    test_backpressure();
    test_load_then_store();
    test_random();
    test_misaligned();
    test_stray();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
